// File: rtl/bridge_fc_manager_pkg.sv
// Shared types and helpers for the PCIe bridge flow-credit manager.
// Covers class encoding, FSM states, the fc_sel code and data credit sizing.
package bridge_fc_pkg;

  typedef enum logic [1:0] {
    CLS_P    = 2'd0,
    CLS_NP   = 2'd1,
    CLS_CPL  = 2'd2,
    CLS_NONE = 2'd3
  } fc_class_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } fc_state_e;

  localparam logic [2:0] FC_SEL_TX_AVAIL = 3'b100;
  localparam int         CNT_W           = 16;
  localparam int         DCRED_W         = 9;

  // A payload of 1024 DW is encoded as len = 0 and costs 256 data credits.
  function automatic logic [DCRED_W-1:0] data_credits(input logic [9:0] len);
    logic [10:0] sum;
    if (len == 10'd0) begin
      return 9'd256;
    end
    sum = 11'(len) + 11'd3;
    return DCRED_W'(sum >> 2);
  endfunction

endpackage

// File: rtl/bridge_fc_manager_if.sv
// Bundle between the PCIe core fc_* port, the transmit path and the credit manager.
// slave = the credit manager; master = the core/transmit side driving it.
interface bridge_fc_manager_if #(
  parameter int HDR_W  = 8,
  parameter int DATA_W = 12
);
  logic              Fcm_Link_Up;
  logic [HDR_W-1:0]  Fcm_fc_ph;
  logic [HDR_W-1:0]  Fcm_fc_nph;
  logic [HDR_W-1:0]  Fcm_fc_cplh;
  logic [DATA_W-1:0] Fcm_fc_pd;
  logic [DATA_W-1:0] Fcm_fc_npd;
  logic [DATA_W-1:0] Fcm_fc_cpld;
  logic              Fcm_Tx_Start;
  logic [1:0]        Fcm_Tx_Type;
  logic [9:0]        Fcm_Tx_Len;
  logic              Fcm_Tx_HasData;
  logic [2:0]        Fcm_fc_sel;
  logic [5:0]        Fcm_Tx_FC;
  logic              Fcm_Bridge_Ready;

  modport master (
    output Fcm_Link_Up, Fcm_fc_ph, Fcm_fc_nph, Fcm_fc_cplh,
           Fcm_fc_pd, Fcm_fc_npd, Fcm_fc_cpld,
           Fcm_Tx_Start, Fcm_Tx_Type, Fcm_Tx_Len, Fcm_Tx_HasData,
    input  Fcm_fc_sel, Fcm_Tx_FC, Fcm_Bridge_Ready
  );

  modport slave (
    input  Fcm_Link_Up, Fcm_fc_ph, Fcm_fc_nph, Fcm_fc_cplh,
           Fcm_fc_pd, Fcm_fc_npd, Fcm_fc_cpld,
           Fcm_Tx_Start, Fcm_Tx_Type, Fcm_Tx_Len, Fcm_Tx_HasData,
    output Fcm_fc_sel, Fcm_Tx_FC, Fcm_Bridge_Ready
  );

endinterface

// File: rtl/bridge_fc_manager_class.sv
// One credit class (P, NP or CPL): header/data shadows with load, saturating
// debit and registered go/no-go flags computed from the next shadow value.
module bridge_fc_class
  import bridge_fc_pkg::*;
#(
  parameter int HDR_W    = 8,
  parameter int DATA_W   = 12,
  parameter int DATA_THR = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic               debit,
  input  logic [HDR_W-1:0]   hdr_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [DCRED_W-1:0] data_debit,
  output logic               hdr_ok,
  output logic               data_ok
);

  localparam int                SUB_W      = (DATA_W > DCRED_W) ? DATA_W : DCRED_W;
  localparam logic [DATA_W-1:0] DATA_THR_V = DATA_W'(DATA_THR);

  logic [HDR_W-1:0]  hdr_q, hdr_base, hdr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SUB_W-1:0]  data_base, data_deb, data_rem;

  // A debit landing on the capture cycle is taken from the freshly captured value.
  always_comb begin
    hdr_base  = load ? hdr_in : hdr_q;
    data_base = SUB_W'(load ? data_in : data_q);
    data_deb  = debit ? SUB_W'(data_debit) : '0;
    data_rem  = (data_base > data_deb) ? (data_base - data_deb) : '0;
    hdr_d     = hdr_base;
    if (debit && (hdr_base != '0)) begin
      hdr_d = hdr_base - HDR_W'(1);
    end
    data_d = DATA_W'(data_rem);
    if (clear) begin
      hdr_d  = '0;
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_q   <= '0;
      data_q  <= '0;
      hdr_ok  <= 1'b0;
      data_ok <= 1'b0;
    end else begin
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      hdr_ok  <= (hdr_d != '0);
      data_ok <= (data_d >= DATA_THR_V);
    end
  end

endmodule

// File: rtl/bridge_fc_manager.sv
// Flow-credit manager: polls the core's Tx-available credits, debits per-class
// shadows as TLPs launch and drives per-class go/no-go flags plus bridge ready.
//   state   | meaning
//   IDLE    | link down, shadows cleared
//   REQ     | fc_sel settling, wait FC_LAT cycles
//   CAPTURE | load all shadows from fc_* inputs
//   HOLD    | debit shadows, wait POLL_INTERVAL cycles
module bridge_fc_manager
  import bridge_fc_pkg::*;
#(
  parameter int HDR_W          = 8,
  parameter int DATA_W         = 12,
  parameter int MAX_PAYLOAD_DW = 256,
  parameter int FC_LAT         = 2,
  parameter int POLL_INTERVAL  = 16
) (
  input  logic                Fcm_CLK,
  input  logic                Fcm_RST_n,
  bridge_fc_manager_if.slave  fcm
);

  localparam int               DATA_THR = MAX_PAYLOAD_DW / 4;
  localparam logic [CNT_W-1:0] REQ_LOAD  = CNT_W'(FC_LAT - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(POLL_INTERVAL - 1);

  fc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               capture;
  logic               link_down;
  logic               debit_ok;
  logic [DCRED_W-1:0] len_credits;
  logic [DCRED_W-1:0] pc_debit, np_debit;
  logic [2:0]         fc_sel_q;
  logic               p_hdr_ok, p_data_ok, np_hdr_ok, np_data_ok, cpl_hdr_ok, cpl_data_ok;

  assign link_down = !fcm.Fcm_Link_Up;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    capture = 1'b0;
    if (link_down) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ready_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_REQ;
          cnt_d   = REQ_LOAD;
        end
        ST_REQ: begin
          if (cnt_q == '0) state_d = ST_CAPTURE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_CAPTURE: begin
          capture = 1'b1;
          ready_d = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            state_d = ST_REQ;
            cnt_d   = REQ_LOAD;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Fcm_CLK or negedge Fcm_RST_n) begin
    if (!Fcm_RST_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      fc_sel_q <= FC_SEL_TX_AVAIL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      fc_sel_q <= FC_SEL_TX_AVAIL;
    end
  end

  // Debits are only trusted once a snapshot exists; before that the shadows are meaningless.
  assign debit_ok    = fcm.Fcm_Link_Up && ready_q && fcm.Fcm_Tx_Start &&
                       (fcm.Fcm_Tx_Type != CLS_NONE);
  assign len_credits = data_credits(fcm.Fcm_Tx_Len);
  assign pc_debit    = fcm.Fcm_Tx_HasData ? len_credits : '0;
  assign np_debit    = fcm.Fcm_Tx_HasData ? DCRED_W'(1) : '0;

  bridge_fc_class #(.HDR_W(HDR_W), .DATA_W(DATA_W), .DATA_THR(DATA_THR)) u_cls_p (
    .clk        (Fcm_CLK),
    .rst_n      (Fcm_RST_n),
    .clear      (link_down),
    .load       (capture),
    .debit      (debit_ok && (fcm.Fcm_Tx_Type == CLS_P)),
    .hdr_in     (fcm.Fcm_fc_ph),
    .data_in    (fcm.Fcm_fc_pd),
    .data_debit (pc_debit),
    .hdr_ok     (p_hdr_ok),
    .data_ok    (p_data_ok)
  );

  bridge_fc_class #(.HDR_W(HDR_W), .DATA_W(DATA_W), .DATA_THR(1)) u_cls_np (
    .clk        (Fcm_CLK),
    .rst_n      (Fcm_RST_n),
    .clear      (link_down),
    .load       (capture),
    .debit      (debit_ok && (fcm.Fcm_Tx_Type == CLS_NP)),
    .hdr_in     (fcm.Fcm_fc_nph),
    .data_in    (fcm.Fcm_fc_npd),
    .data_debit (np_debit),
    .hdr_ok     (np_hdr_ok),
    .data_ok    (np_data_ok)
  );

  bridge_fc_class #(.HDR_W(HDR_W), .DATA_W(DATA_W), .DATA_THR(DATA_THR)) u_cls_cpl (
    .clk        (Fcm_CLK),
    .rst_n      (Fcm_RST_n),
    .clear      (link_down),
    .load       (capture),
    .debit      (debit_ok && (fcm.Fcm_Tx_Type == CLS_CPL)),
    .hdr_in     (fcm.Fcm_fc_cplh),
    .data_in    (fcm.Fcm_fc_cpld),
    .data_debit (pc_debit),
    .hdr_ok     (cpl_hdr_ok),
    .data_ok    (cpl_data_ok)
  );

  assign fcm.Fcm_fc_sel       = fc_sel_q;
  assign fcm.Fcm_Tx_FC        = {cpl_data_ok, cpl_hdr_ok, np_data_ok, np_hdr_ok, p_data_ok, p_hdr_ok};
  assign fcm.Fcm_Bridge_Ready = ready_q;

endmodule

// File: tb/tb_bridge_fc_manager.sv
// Self-checking bench for bridge_fc_manager: a schedule-based credit model
// compared every cycle, plus directed literal checks and randomized traffic.
module tb_bridge_fc_manager;

  localparam int HDR_W          = 8;
  localparam int DATA_W         = 12;
  localparam int MAX_PAYLOAD_DW = 256;
  localparam int FC_LAT         = 2;
  localparam int POLL_INTERVAL  = 16;
  localparam int DTHR           = MAX_PAYLOAD_DW / 4;
  localparam int PERIOD         = FC_LAT + 1 + POLL_INTERVAL;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bridge_fc_manager_if #(.HDR_W(HDR_W), .DATA_W(DATA_W)) fcm_if ();

  bridge_fc_manager #(
    .HDR_W(HDR_W), .DATA_W(DATA_W), .MAX_PAYLOAD_DW(MAX_PAYLOAD_DW),
    .FC_LAT(FC_LAT), .POLL_INTERVAL(POLL_INTERVAL)
  ) dut (
    .Fcm_CLK   (clk),
    .Fcm_RST_n (rst_n),
    .fcm       (fcm_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: shadows per class (0=P,1=NP,2=CPL); captures happen on a fixed
  // schedule counted in clock edges from the edge that first sees link-up.
  int m_h[3];
  int m_d[3];
  bit m_ready  = 1'b0;
  bit m_linked = 1'b0;
  bit m_cap    = 1'b0;
  int m_e      = 0;

  function automatic int dcred(input int len);
    return (len == 0) ? 256 : (len + 3) / 4;
  endfunction

  function automatic logic [5:0] exp_fc();
    return {m_d[2] >= DTHR, m_h[2] >= 1, m_d[1] >= 1, m_h[1] >= 1, m_d[0] >= DTHR, m_h[0] >= 1};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_h[i] = 0;
      m_d[i] = 0;
    end
    m_ready  = 1'b0;
    m_linked = 1'b0;
    m_e      = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst_n);
      m_cap = 1'b0;
      if (!rst_n || !fcm_if.Fcm_Link_Up) begin
        model_clear();
      end else begin
        bit cap;
        int typ;
        int dd;
        if (!m_linked) begin
          m_linked = 1'b1;
          m_e      = 0;
        end else begin
          m_e++;
        end
        cap = (m_e >= FC_LAT + 1) && (((m_e - FC_LAT - 1) % PERIOD) == 0);
        if (cap) begin
          m_h[0] = int'(fcm_if.Fcm_fc_ph);
          m_h[1] = int'(fcm_if.Fcm_fc_nph);
          m_h[2] = int'(fcm_if.Fcm_fc_cplh);
          m_d[0] = int'(fcm_if.Fcm_fc_pd);
          m_d[1] = int'(fcm_if.Fcm_fc_npd);
          m_d[2] = int'(fcm_if.Fcm_fc_cpld);
        end
        typ = int'(fcm_if.Fcm_Tx_Type);
        if (m_ready && fcm_if.Fcm_Tx_Start && typ != 3) begin
          m_h[typ] = (m_h[typ] > 0) ? m_h[typ] - 1 : 0;
          if (fcm_if.Fcm_Tx_HasData) begin
            dd = (typ == 1) ? 1 : dcred(int'(fcm_if.Fcm_Tx_Len));
            m_d[typ] = (m_d[typ] > dd) ? m_d[typ] - dd : 0;
          end
        end
        if (cap) m_ready = 1'b1;
        m_cap = cap;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_tx_fc", 32'(fcm_if.Fcm_Tx_FC), 32'(exp_fc()));
      check("model_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'(m_ready));
      check("model_fc_sel", 32'(fcm_if.Fcm_fc_sel), 32'h4);
    end
  end

  task automatic set_fc(input int ph, input int nph, input int cplh,
                        input int pd, input int npd, input int cpld);
    fcm_if.Fcm_fc_ph   = HDR_W'(ph);
    fcm_if.Fcm_fc_nph  = HDR_W'(nph);
    fcm_if.Fcm_fc_cplh = HDR_W'(cplh);
    fcm_if.Fcm_fc_pd   = DATA_W'(pd);
    fcm_if.Fcm_fc_npd  = DATA_W'(npd);
    fcm_if.Fcm_fc_cpld = DATA_W'(cpld);
  endtask

  // Called just after a negedge; pulses Tx_Start across one rising edge.
  task automatic send(input int typ, input bit hd, input int len);
    fcm_if.Fcm_Tx_Start   = 1'b1;
    fcm_if.Fcm_Tx_Type    = 2'(typ);
    fcm_if.Fcm_Tx_HasData = hd;
    fcm_if.Fcm_Tx_Len     = 10'(len);
    @(negedge clk);
    fcm_if.Fcm_Tx_Start   = 1'b0;
  endtask

  task automatic wait_cap(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_cap && n < budget);
    if (!m_cap) begin
      checks++;
      errors++;
      $display("FAIL wait_cap: no capture within %0d cycles", budget);
    end
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    fcm_if.Fcm_Link_Up    = 1'b0;
    fcm_if.Fcm_Tx_Start   = 1'b0;
    fcm_if.Fcm_Tx_Type    = 2'd0;
    fcm_if.Fcm_Tx_Len     = 10'd0;
    fcm_if.Fcm_Tx_HasData = 1'b0;
    set_fc(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_tx_fc", 32'(fcm_if.Fcm_Tx_FC), 32'h0);
    check("reset_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h0);
    check("reset_fc_sel", 32'(fcm_if.Fcm_fc_sel), 32'h4);

    // First snapshot after link-up
    set_fc(8, 4, 0, 128, 8, 0);
    @(negedge clk);
    fcm_if.Fcm_Link_Up = 1'b1;
    repeat (FC_LAT + 1) @(negedge clk);
    check("linkup_not_ready_yet", 32'(fcm_if.Fcm_Bridge_Ready), 32'h0);
    @(negedge clk);
    check("linkup_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h1);
    check("linkup_tx_fc", 32'(fcm_if.Fcm_Tx_FC), 32'b001111);

    // Posted debit to below threshold, then drain the header credits
    set_fc(8, 4, 0, 70, 8, 0);
    wait_cap(PERIOD + 2);
    check("pd70_ok", 32'(fcm_if.Fcm_Tx_FC[1]), 32'h1);
    send(0, 1'b1, 32);
    check("pd62_low", 32'(fcm_if.Fcm_Tx_FC[1]), 32'h0);
    check("ph7_ok", 32'(fcm_if.Fcm_Tx_FC[0]), 32'h1);
    repeat (6) send(0, 1'b0, 1);
    check("ph1_ok", 32'(fcm_if.Fcm_Tx_FC[0]), 32'h1);
    send(0, 1'b0, 1);
    check("ph0_low", 32'(fcm_if.Fcm_Tx_FC[0]), 32'h0);

    // Length 0 is 256 credits and saturates
    set_fc(8, 4, 1, 128, 8, 64);
    wait_cap(PERIOD + 2);
    send(0, 1'b1, 0);
    check("len0_saturates", 32'(fcm_if.Fcm_Tx_FC[1]), 32'h0);

    // len=5 costs 2 credits, len=1 costs 1; NP with data costs 1; CPL
    set_fc(4, 4, 1, 66, 1, 64);
    wait_cap(PERIOD + 2);
    send(0, 1'b1, 5);
    check("len5_pd64", 32'(fcm_if.Fcm_Tx_FC[1]), 32'h1);
    send(0, 1'b1, 1);
    check("len1_pd63", 32'(fcm_if.Fcm_Tx_FC[1]), 32'h0);
    send(1, 1'b1, 7);
    check("np_data", 32'(fcm_if.Fcm_Tx_FC[3:2]), 32'b01);
    check("cpl_before", 32'(fcm_if.Fcm_Tx_FC[5:4]), 32'b11);
    send(2, 1'b1, 4);
    check("cpl_after", 32'(fcm_if.Fcm_Tx_FC[5:4]), 32'b00);

    // Debit landing in the capture cycle
    set_fc(10, 4, 1, 100, 8, 100);
    wait_cap(PERIOD + 2);
    repeat (PERIOD - 1) @(negedge clk);
    send(0, 1'b0, 1);
    check("collide_ph9", 32'(fcm_if.Fcm_Tx_FC[0]), 32'h1);
    repeat (8) send(0, 1'b0, 1);
    check("collide_ph1", 32'(fcm_if.Fcm_Tx_FC[0]), 32'h1);
    send(0, 1'b0, 1);
    check("collide_ph0", 32'(fcm_if.Fcm_Tx_FC[0]), 32'h0);

    // Link drop during HOLD, then relink
    wait_cap(PERIOD + 2);
    repeat (3) @(negedge clk);
    fcm_if.Fcm_Link_Up = 1'b0;
    send(0, 1'b1, 4);
    check("drop_tx_fc", 32'(fcm_if.Fcm_Tx_FC), 32'h0);
    check("drop_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h0);
    send(1, 1'b1, 4);
    check("drop_ignore_tx", 32'(fcm_if.Fcm_Tx_FC), 32'h0);
    set_fc(3, 0, 2, 64, 0, 100);
    fcm_if.Fcm_Link_Up = 1'b1;
    repeat (FC_LAT + 1) @(negedge clk);
    check("relink_not_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h0);
    @(negedge clk);
    check("relink_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h1);
    check("relink_tx_fc", 32'(fcm_if.Fcm_Tx_FC), 32'b110011);

    // Asynchronous reset while in REQ
    wait_cap(PERIOD + 2);
    repeat (POLL_INTERVAL) @(negedge clk);
    check("prereset_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tx_fc", 32'(fcm_if.Fcm_Tx_FC), 32'h0);
    check("async_rst_ready", 32'(fcm_if.Fcm_Bridge_Ready), 32'h0);
    check("async_rst_fc_sel", 32'(fcm_if.Fcm_fc_sel), 32'h4);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic checked by the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 1) == 0)
        fcm_if.Fcm_fc_ph = HDR_W'($urandom_range(0, 3));
      else
        fcm_if.Fcm_fc_ph = HDR_W'($urandom_range(0, 255));
      fcm_if.Fcm_fc_nph  = HDR_W'($urandom_range(0, 4));
      fcm_if.Fcm_fc_cplh = HDR_W'($urandom_range(0, 6));
      fcm_if.Fcm_fc_pd   = DATA_W'($urandom_range(55, 75));
      fcm_if.Fcm_fc_npd  = DATA_W'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        fcm_if.Fcm_fc_cpld = DATA_W'($urandom_range(0, 4095));
      else
        fcm_if.Fcm_fc_cpld = DATA_W'($urandom_range(60, 300));
      fcm_if.Fcm_Tx_Start   = ($urandom_range(0, 1) == 1);
      fcm_if.Fcm_Tx_Type    = 2'($urandom_range(0, 3));
      fcm_if.Fcm_Tx_HasData = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0)
        fcm_if.Fcm_Tx_Len = 10'd0;
      else
        fcm_if.Fcm_Tx_Len = 10'($urandom_range(1, 1023));
      if (fcm_if.Fcm_Link_Up && $urandom_range(0, 199) == 0)
        fcm_if.Fcm_Link_Up = 1'b0;
      else if (!fcm_if.Fcm_Link_Up && $urandom_range(0, 3) == 0)
        fcm_if.Fcm_Link_Up = 1'b1;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    fcm_if.Fcm_Tx_Start = 1'b0;
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bridge_fc_manager.md
# bridge_fc_manager

Parametrised flow-credit manager for the PCIe bridge, superseding the fixed MSB-test credit check in the bridge control block. It periodically samples the core's transmit-available credit counters, keeps a per-class shadow count that is debited as the transmit path launches TLPs, and drives per-class go/no-go flags plus a bridge-ready flag. It sits between the PCIe core's `fc_*` interface and the transmit bridge module.

## Interface
- `HDR_W`, 8: header credit width.
- `DATA_W`, 12: data credit width.
- `MAX_PAYLOAD_DW`, 256: max payload size in DW. Posted and completion data threshold is `MAX_PAYLOAD_DW/4` credits.
- `FC_LAT`, 2: cycles from `Fcm_fc_sel` being stable until the `fc_*` inputs are valid.
- `POLL_INTERVAL`, 16: cycles between snapshot requests (≥1).

- `Fcm_CLK`, in, 1: single clock.
- `Fcm_RST_n`, in, 1: reset, asynchronous, active-low.
- `Fcm_Link_Up`, in, 1: core link-up.
- `Fcm_fc_ph`, `Fcm_fc_nph`, `Fcm_fc_cplh`, in, `HDR_W`: available header credits.
- `Fcm_fc_pd`, `Fcm_fc_npd`, `Fcm_fc_cpld`, in, `DATA_W`: available data credits.
- `Fcm_Tx_Start`, in, 1: one-cycle pulse; the transmit path launches a TLP.
- `Fcm_Tx_Type`, in, 2: 0 = P, 1 = NP, 2 = CPL, 3 = ignored.
- `Fcm_Tx_Len`, in, 10: payload length in DW; 0 encodes 1024; meaningful only for P/CPL with data.
- `Fcm_Tx_HasData`, in, 1: TLP carries payload.
- `Fcm_fc_sel`, out, 3: flow-control select to core; always 3'b100 (Tx available).
- `Fcm_Tx_FC`, out, 6: bit order {CPLD, CPLH, NPD, NPH, PD, PH}; 1 = sufficient credit.
- `Fcm_Bridge_Ready`, out, 1: link up and at least one valid snapshot taken.

## Operation
- **FSM states:** IDLE, REQ, CAPTURE, HOLD.
  - IDLE → REQ when `Fcm_Link_Up` = 1.
  - REQ counts `FC_LAT` cycles, then → CAPTURE.
  - CAPTURE lasts one cycle: it loads all six shadows from the inputs, then → HOLD.
  - HOLD counts `POLL_INTERVAL` cycles, then → REQ.
  - `Fcm_Link_Up` = 0 in any state → IDLE next cycle, with all shadows cleared, `Fcm_Tx_FC` = 0 and ready = 0.
- **Debit:** applies on `Fcm_Tx_Start` with type ≠ 3 and ready = 1; it is ignored otherwise.
  - Header shadow of the class −1.
  - If `HasData`, data shadow −ceil(len/4), computed as (len+3)>>2 with len = 0 → 256 credits.
  - NP with data debits 1 data credit.
  - All subtraction saturates at 0.
- **Capture and debit in the same cycle:** shadow = sat(captured − debit).
- **Flag thresholds:** each `Fcm_Tx_FC` bit is computed from the next-state shadow.
  - Header bits: shadow ≥ 1.
  - PD and CPLD: shadow ≥ `MAX_PAYLOAD_DW/4`.
  - NPD: shadow ≥ 1.
- `Fcm_Bridge_Ready` is set on leaving the first CAPTURE after link-up. It is cleared on link down or reset.

## Timing
- **Reset values:**
  - `Fcm_fc_sel` = 3'b100
  - `Fcm_Tx_FC` = 6'b0
  - `Fcm_Bridge_Ready` = 0
  - FSM = IDLE
  - shadows = 0
  - counters = 0
- All outputs are registered.
- A debit at edge N is reflected in `Fcm_Tx_FC` after edge N (visible cycle N+1).
- **First snapshot latency:** link-up sampled at edge L gives REQ at L+1, CAPTURE at L+1+`FC_LAT`, and ready plus valid flags after that edge.
- **Poll period:** `FC_LAT` + 1 + `POLL_INTERVAL` cycles.
- Link drop mid-REQ/CAPTURE aborts the cycle; no partial capture.
- Reset assertion mid-operation returns all outputs to their reset values immediately (asynchronous).

## Structure
- **Package `bridge_fc_pkg`:**
  - class encoding (P/NP/CPL)
  - FSM state enum
  - `FC_SEL_TX_AVAIL` = 3'b100
  - function `data_credits(len)` returning ceil(len/4) with the 0 → 256 rule
- **Sub-module `bridge_fc_class`**, instantiated three times. Per class it holds:
  - header and data shadow registers
  - load on capture
  - saturating debit
  - two threshold comparators (data threshold passed as a parameter)

## Test plan
- **Reset/link-up:** reset, link-up at cycle 5, inputs ph=8, pd=128, nph=4, npd=8, cplh=0, cpld=0 → at cycle 5+1+2+1 ready=1 and `Fcm_Tx_FC`=6'b001111; `Fcm_fc_sel`=3'b100 throughout.
- **Posted debit to threshold:** pd=70, P TLP with data, len=32 DW → shadow 62, PD bit drops (62<64) the next cycle; ph decrements 8→7.
- **Length rules and saturation:** len=0 debits 256 → pd 128 saturates to 0; len=5 debits 2 credits; NP with data debits npd by 1.
- **Capture/debit collision:** in the CAPTURE cycle, Tx_Start P with inputs ph=10 → shadow 9.
- **Link drop:** link drop during HOLD → next cycle `Fcm_Tx_FC`=0, ready=0, Tx_Start ignored; relink → fresh snapshot after `FC_LAT`+1 cycles.
- **Mid-REQ reset:** asynchronous reset mid-REQ → outputs at reset values immediately; type=3 pulses never change any shadow.
